sw_event_port: RTL and testbench

- Memory-mapped input responder on the processor data bus, complementing the output-only io block on the same bus.
- Synchronizes and debounces the slide switches.
- Timestamps every change of the debounced switch vector and queues it in a small FIFO.
- The processor drains the FIFO with loads; the top-level read mux selects this block when its hit output is high.

---
 rtl/sw_event_port.sv | 198 +++++++++++++++++++
 tb/tb_sw_event_port.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_event_port.sv
// Debounced slide-switch input port with a timestamped change-event FIFO on the data bus.
// Optional macro SW_EVENT_IRQ_EN adds a registered irq output and an IRQ_MASK bit in CTRL/STATUS.
module sw_event_port #(
  parameter int               WIDTH      = 32,
  parameter int               SW_WIDTH   = 18,
  parameter logic [WIDTH-1:0] BASE_ADDR  = 32'd260,
  parameter int               FIFO_DEPTH = 8,
  parameter int               DB_CYCLES  = 250000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    addr,
  input  logic [WIDTH-1:0]    data_in,
  input  logic [2:0]          MemLen,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [SW_WIDTH-1:0] sw_in,
  output logic                hit,
`ifdef SW_EVENT_IRQ_EN
  output logic                irq,
`endif
  output logic [WIDTH-1:0]    data_out
);
  // state    | meaning
  // ST_FILL0 | no post-reset debounce sample taken yet
  // ST_FILL1 | one post-reset sample held (s_new only)
  // ST_WAIT  | both samples real; first stable tick seeds the level, no event
  // ST_RUN   | init done; stable changes update level and push events
  typedef enum logic [1:0] {ST_FILL0, ST_FILL1, ST_WAIT, ST_RUN} state_t;

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int DBW = $clog2(DB_CYCLES);

  state_t              state, state_nxt;
  logic [SW_WIDTH-1:0] sync1, sync2, s_new, s_old, level;
  logic [DBW-1:0]      div_cnt;
  logic [12:0]         ts;
  logic                tick, stable, load_lvl, push_req;
  logic                enable, ovf, irq_mask_bit;
  logic [30:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       count;
  logic                empty, full, pop, flush, do_push, ovf_set, wr_ctrl, rd_data;
  logic [WIDTH-1:0]    offs;
  logic [1:0]          reg_sel;
  logic [31:0]         count_ext;
  logic [3:0]          cnt_cap;
  logic [8:0]          status_word;
  logic                unused_bits;

  assign unused_bits = ^{MemLen, data_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
    end
  end

  assign tick = (div_cnt == DBW'(DB_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      s_new   <= '0;
      s_old   <= '0;
      ts      <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DBW'(1);
      if (tick) begin
        s_new <= sync2;
        s_old <= s_new;
        ts    <= ts + 13'd1;
      end
    end
  end

  assign stable = (s_new == s_old);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FILL0;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL0: if (tick)           state_nxt = ST_FILL1;
      ST_FILL1: if (tick)           state_nxt = ST_WAIT;
      ST_WAIT:  if (tick && stable) state_nxt = ST_RUN;
      default:                      state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    load_lvl = 1'b0;
    push_req = 1'b0;
    if (tick && stable) begin
      if (state == ST_WAIT) begin
        load_lvl = 1'b1;
      end else if (state == ST_RUN && s_new != level) begin
        load_lvl = 1'b1;
        push_req = enable;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        level <= '0;
    else if (load_lvl) level <= s_new;
  end

  // BASE_ADDR is word-aligned, so the low offset bits equal the low address bits
  assign offs    = addr - BASE_ADDR;
  assign hit     = (offs < WIDTH'(16)) && (offs[1:0] == 2'b00);
  assign reg_sel = offs[3:2];
  assign wr_ctrl = MemWrite && hit && (reg_sel == 2'd3);
  assign rd_data = MemRead && hit && (reg_sel == 2'd1);

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = rd_data && !empty;
  assign flush   = wr_ctrl && data_in[1];
  assign do_push = push_req && (!full || pop) && !flush;
  assign ovf_set = push_req && full && !pop && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !pop)      count <= count + CW'(1);
      else if (!do_push && pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= {ts, 18'(s_new)};
  end

  // an overflowing push outranks a coincident clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf    <= 1'b0;
      enable <= 1'b1;
    end else begin
      if (ovf_set)                     ovf <= 1'b1;
      else if (wr_ctrl && data_in[0])  ovf <= 1'b0;
      if (wr_ctrl) enable <= data_in[2];
    end
  end

`ifdef SW_EVENT_IRQ_EN
  logic irq_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_mask <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr_ctrl) irq_mask <= data_in[3];
      irq <= !empty && irq_mask;
    end
  end

  assign irq_mask_bit = irq_mask;
`else
  assign irq_mask_bit = 1'b0;
`endif

  assign count_ext   = 32'(count);
  assign cnt_cap     = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
  assign status_word = {irq_mask_bit, cnt_cap, enable, ovf, full, empty};

  always_comb begin
    data_out = '0;
    if (hit) begin
      case (reg_sel)
        2'd0:    data_out = WIDTH'(status_word);
        2'd1:    if (!empty) data_out = WIDTH'({1'b1, mem[rd_ptr]});
        2'd2:    data_out = WIDTH'(level);
        default: data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_event_port.sv
// Bench for sw_event_port: fixed decode table, directed corner sequences and randomized
// traffic checked against a queue-based model of the event port.
module tb_sw_event_port;
  localparam int          DB    = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'd260;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_in = '0;
  logic [2:0]  MemLen = 3'd2;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [17:0] sw_in = 18'h00005;
  logic        hit;
  logic [31:0] data_out;
`ifdef SW_EVENT_IRQ_EN
  logic        irq;
`endif

  int tests = 0;
  int fails = 0;

  sw_event_port #(.DB_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in), .MemLen(MemLen),
    .MemRead(MemRead), .MemWrite(MemWrite), .sw_in(sw_in), .hit(hit),
`ifdef SW_EVENT_IRQ_EN
    .irq(irq),
`endif
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [17:0] hist[$];
  logic [17:0] smp[$];
  logic [31:0] mq[$];
  bit          m_ovf, m_en, m_init, m_mask, m_irq;
  logic [17:0] m_level;
  int          ecnt, m_ts;

  function automatic void m_reset();
    hist = '{18'd0, 18'd0, 18'd0};
    smp.delete();
    mq.delete();
    m_ovf = 0; m_en = 1; m_init = 0; m_mask = 0; m_irq = 0;
    m_level = '0; ecnt = 0; m_ts = 0;
  endfunction

  function automatic void m_step();
    logic [17:0] sample;
    logic [31:0] ev;
    bit tick, push, pop, wr;
    hist.push_back(sw_in);
    void'(hist.pop_front());
    sample = hist[0];
    tick = (ecnt % DB) == DB - 1;
    ecnt++;
    wr   = MemWrite && addr == BASE + 12;
    pop  = MemRead && addr == BASE + 4 && mq.size() != 0;
    push = 0;
    ev   = '0;
    m_irq = (mq.size() != 0) && m_mask;
    if (tick) begin
      if (smp.size() == 2 && smp[0] == smp[1]) begin
        if (!m_init) begin
          m_init = 1;
          m_level = smp[1];
        end else if (smp[1] != m_level) begin
          m_level = smp[1];
          push = m_en;
          ev = {1'b1, 13'(m_ts), m_level};
        end
      end
      smp.push_back(sample);
      if (smp.size() > 2) void'(smp.pop_front());
      m_ts = (m_ts + 1) % 8192;
    end
    if (wr && data_in[0]) m_ovf = 0;
    if (wr && data_in[1]) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < DEPTH) mq.push_back(ev);
        else m_ovf = 1;
      end
    end
    if (wr) m_en = data_in[2];
`ifdef SW_EVENT_IRQ_EN
    if (wr) m_mask = data_in[3];
`endif
  endfunction

  initial begin : model
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  function automatic logic mhit(logic [31:0] a);
    return a == BASE || a == BASE + 4 || a == BASE + 8 || a == BASE + 12;
  endfunction

  function automatic logic [31:0] mread(logic [31:0] a);
    int n = mq.size();
    logic [31:0] r = '0;
    if (a == BASE)
      r = {23'd0, m_mask, 4'(n > 15 ? 15 : n), m_en, m_ovf, n == DEPTH, n == 0};
    else if (a == BASE + 4)
      r = (n != 0) ? mq[0] : 32'd0;
    else if (a == BASE + 8)
      r = {14'd0, m_level};
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    MemRead = 1'b1;
    #1;
    d = data_out;
    @(posedge clk);
    #1;
    MemRead = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    addr = a;
    data_in = v;
    MemWrite = 1'b1;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    data_in = '0;
  endtask

  task automatic sw_change(input logic [17:0] v);
    sw_in = v;
    cyc(3 * DB + 3);
  endtask

  // leaves time just after a tick edge
  task automatic align_tick();
    for (int k = 0; k < DB && (ecnt % DB) != 0; k++) cyc(1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic        h;
    logic [31:0] d;
    string       nm;
  } vec_t;

  vec_t        tbl[8];
  logic [31:0] d, exp_ev;
  logic [31:0] addrs[6];

  initial begin
    tbl[0] = '{BASE,      1'b1, 32'h9, "tbl_status"};
    tbl[1] = '{BASE + 4,  1'b1, 32'h0, "tbl_data_empty"};
    tbl[2] = '{BASE + 8,  1'b1, 32'h5, "tbl_level"};
    tbl[3] = '{BASE + 12, 1'b1, 32'h0, "tbl_ctrl"};
    tbl[4] = '{BASE + 16, 1'b0, 32'h0, "tbl_past_end"};
    tbl[5] = '{BASE + 2,  1'b0, 32'h0, "tbl_misaligned"};
    tbl[6] = '{BASE - 4,  1'b0, 32'h0, "tbl_below"};
    tbl[7] = '{BASE + 9,  1'b0, 32'h0, "tbl_odd"};
    addrs = '{BASE, BASE + 4, BASE + 8, BASE + 12, BASE + 16, BASE + 2};

    cyc(3);
    addr = BASE + 8; #1;
    chk("rst_level", data_out, 32'h0);
    addr = BASE + 4; #1;
    chk("rst_data", data_out, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(3 * DB + 2);

    for (int i = 0; i < 8; i++) begin
      addr = tbl[i].a;
      #1;
      chk({tbl[i].nm, "_data"}, data_out, tbl[i].d);
      chk({tbl[i].nm, "_hit"}, {31'd0, hit}, {31'd0, tbl[i].h});
    end

    // single change
    sw_change(18'h00007);
    rd(BASE, d);
    chk("single_status", d, 32'h18);
    exp_ev = mread(BASE + 4);
    rd(BASE + 4, d);
    chk("single_ev_flag", {31'd0, d[31]}, 32'd1);
    chk("single_ev_vec", {14'd0, d[17:0]}, 32'h7);
    chk("single_ev_word", d, exp_ev);
    rd(BASE + 4, d);
    chk("single_reread", d, 32'h0);
    rd(BASE, d);
    chk("single_status_after", d, 32'h9);

    // glitch shorter than a debounce interval
    align_tick();
    cyc(1);
    sw_in = sw_in ^ 18'h00200;
    cyc(2);
    sw_in = sw_in ^ 18'h00200;
    cyc(3 * DB + 3);
    rd(BASE + 8, d);
    chk("glitch_level", d, 32'h7);
    rd(BASE, d);
    chk("glitch_status", d, 32'h9);

    // overflow, then clear (writes also load ENABLE from bit2)
    for (int k = 0; k < 9; k++) sw_change(18'h00100 + 18'(k));
    rd(BASE, d);
    chk("ovf_status", d, 32'h8E);
    wr(BASE + 12, 32'h1);
    rd(BASE, d);
    chk("ovf_clear", d, 32'h82);
    wr(BASE + 12, 32'h2);
    rd(BASE, d);
    chk("flush_status", d, 32'h01);

    // refill to full, then pop aligned with a push tick
    wr(BASE + 12, 32'h4);
    for (int k = 0; k < 8; k++) sw_change(18'h00200 + 18'(k));
    rd(BASE, d);
    chk("refill_status", d, 32'h8A);
    align_tick();
    sw_in = 18'h00300;
    cyc(3 * DB - 1);
    exp_ev = mread(BASE + 4);
    rd(BASE + 4, d);
    chk("poppush_data", d, exp_ev);
    rd(BASE, d);
    chk("poppush_status", d, 32'h8A);
    rd(BASE + 8, d);
    chk("poppush_level", d, 32'h300);

    // flush aligned with a push tick
    align_tick();
    sw_in = 18'h00301;
    cyc(3 * DB - 1);
    wr(BASE + 12, 32'h6);
    rd(BASE, d);
    chk("flushpush_status", d, 32'h09);
    rd(BASE + 8, d);
    chk("flushpush_level", d, 32'h301);

    // disabled: level tracks, no events
    wr(BASE + 12, 32'h0);
    sw_change(18'h3A5A5);
    rd(BASE + 8, d);
    chk("dis_level1", d, 32'h3A5A5);
    sw_change(18'h00012);
    rd(BASE + 8, d);
    chk("dis_level2", d, 32'h12);
    rd(BASE, d);
    chk("dis_status", d, 32'h01);

    // randomized traffic against the model
    wr(BASE + 12, 32'h4);
    for (int i = 0; i < 4000; i++) begin
      int r;
      bit rd_on;
      r = $urandom_range(0, 99);
      rd_on = ((i / 500) % 2) == 1;
      if (r < 2) sw_in = 18'($urandom);
      else if (r < 4) sw_in = sw_in ^ (18'd1 << $urandom_range(0, 17));
      addr = addrs[$urandom_range(0, 5)];
      MemRead = rd_on && !MemRead && ($urandom_range(0, 3) == 0);
      MemWrite = !MemRead && ($urandom_range(0, 39) == 0);
      data_in = $urandom;
      if ($urandom_range(0, 3) != 0) data_in[1] = 1'b0;
      if ($urandom_range(0, 9) != 0) data_in[2] = 1'b1;
      #1;
      chk("rand_data", data_out, mread(addr));
      chk("rand_hit", {31'd0, hit}, {31'd0, mhit(addr)});
`ifdef SW_EVENT_IRQ_EN
      chk("rand_irq", {31'd0, irq}, {31'd0, m_irq});
`endif
      @(posedge clk);
      #1;
    end
    MemRead = 1'b0;
    MemWrite = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
